// File: rtl/bnb_pkg.sv
// Shared scancode and direction constants for the key decoder and game-logic block.
// Direction encoding is also consumed directly by calc.
package bnb_pkg;

   localparam logic [1:0] DIR_UP    = 2'd0;
   localparam logic [1:0] DIR_DOWN  = 2'd1;
   localparam logic [1:0] DIR_LEFT  = 2'd2;
   localparam logic [1:0] DIR_RIGHT = 2'd3;

   localparam logic [7:0] SC_EXT      = 8'hE0;
   localparam logic [7:0] SC_BRK      = 8'hF0;
   localparam logic [7:0] SC_PAUSE    = 8'hE1;
   localparam logic [7:0] SC_P1_UP    = 8'h1D;
   localparam logic [7:0] SC_P1_DOWN  = 8'h1B;
   localparam logic [7:0] SC_P1_LEFT  = 8'h1C;
   localparam logic [7:0] SC_P1_RIGHT = 8'h23;
   localparam logic [7:0] SC_P1_BUB   = 8'h29;
   localparam logic [7:0] SC_P2_BUB   = 8'h5A;
   localparam logic [7:0] SC_P2_UP    = 8'h75;
   localparam logic [7:0] SC_P2_DOWN  = 8'h72;
   localparam logic [7:0] SC_P2_LEFT  = 8'h6B;
   localparam logic [7:0] SC_P2_RIGHT = 8'h74;

   typedef struct packed {
      logic [3:0] dir_make;
      logic [3:0] dir_brk;
      logic       bub_make;
      logic       bub_brk;
   } key_evt_t;

   function automatic logic [3:0] dir_onehot(input logic [1:0] dir);
      return 4'(1) << dir;
   endfunction

   // Fallback priority: up > down > left > right.
   function automatic logic [1:0] lowest_dir(input logic [3:0] mask);
      logic [1:0] res;
      res = DIR_UP;
      for (int i = 3; i >= 0; i--) begin
         if (mask[i]) res = 2'(i);
      end
      return res;
   endfunction

endpackage

// File: rtl/bnb_player_keys.sv
// Held-key state for one player: direction mask, last-pressed with fallback, bubble flag and pulse.
// Outputs reflect an event one cycle after its strobe; no backpressure, one event per cycle.
module bnb_player_keys
   import bnb_pkg::*;
#(
   parameter int unsigned BUBBLE_PULSE = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clear_i,
   input  key_evt_t   evt_i,
   output logic       moveen_o,
   output logic [1:0] move_o,
   output logic       bubble_o
);

   localparam logic [3:0] PULSE_LEN = 4'(BUBBLE_PULSE);

   logic [3:0] mask_q, mask_d;
   logic [1:0] last_q, last_d;
   logic       flag_q, flag_d;
   logic [3:0] cnt_q,  cnt_d;

   always_comb begin
      mask_d = (mask_q | evt_i.dir_make) & ~evt_i.dir_brk;
      last_d = last_q;
      if (evt_i.dir_make != 4'd0) begin
         last_d = lowest_dir(evt_i.dir_make);
      end else if (((evt_i.dir_brk & dir_onehot(last_q)) != 4'd0) && (mask_d != 4'd0)) begin
         last_d = lowest_dir(mask_d);
      end

      flag_d = (flag_q | evt_i.bub_make) & ~evt_i.bub_brk;
      cnt_d  = cnt_q;
      // A new press only fires when the key was released in between.
      if (evt_i.bub_make && !flag_q) begin
         cnt_d = PULSE_LEN;
      end else if (cnt_q != 4'd0) begin
         cnt_d = cnt_q - 4'd1;
      end

      if (clear_i) begin
         mask_d = 4'd0;
         last_d = DIR_UP;
         flag_d = 1'b0;
         cnt_d  = 4'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mask_q <= 4'd0;
         last_q <= DIR_UP;
         flag_q <= 1'b0;
         cnt_q  <= 4'd0;
      end else begin
         mask_q <= mask_d;
         last_q <= last_d;
         flag_q <= flag_d;
         cnt_q  <= cnt_d;
      end
   end

   assign moveen_o = |mask_q;
   assign move_o   = last_q;
   assign bubble_o = (cnt_q != 4'd0);

endmodule

// File: rtl/bnb_key_decoder.sv
// PS/2 scancode parser producing per-player move/bubble commands for the game-logic block.
// Outputs update one cycle after the final byte of a sequence; the receiver is never stalled.
module bnb_key_decoder
   import bnb_pkg::*;
#(
   parameter int unsigned BUBBLE_PULSE = 1,
   parameter bit          CLEAR_ON_ERR = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   input  logic       rx_err,
   input  logic       clear,
   output logic       player1_moveen,
   output logic [1:0] player1_move,
   output logic       player1_bubble,
   output logic       player2_moveen,
   output logic [1:0] player2_move,
   output logic       player2_bubble
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_EXT     = 2'd1;
   localparam logic [1:0] ST_BRK     = 2'd2;
   localparam logic [1:0] ST_EXT_BRK = 2'd3;

   logic [1:0] state_q, state_d;
   logic       dec_en, dec_ext, dec_brk;
   logic [3:0] p1_dir, p2_dir;
   logic       p1_bub, p2_bub;
   key_evt_t   p1_evt, p2_evt;
   logic       held_clr;

   always_comb begin
      state_d = state_q;
      dec_en  = 1'b0;
      dec_ext = 1'b0;
      dec_brk = 1'b0;
      if (rx_err) begin
         state_d = ST_IDLE;
      end else if (rx_valid) begin
         if (rx_data == SC_PAUSE) begin
            state_d = ST_IDLE;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (rx_data == SC_EXT)      state_d = ST_EXT;
                  else if (rx_data == SC_BRK) state_d = ST_BRK;
                  else                        dec_en  = 1'b1;
               end
               ST_EXT: begin
                  if (rx_data == SC_BRK) begin
                     state_d = ST_EXT_BRK;
                  end else begin
                     state_d = ST_IDLE;
                     dec_en  = 1'b1;
                     dec_ext = 1'b1;
                  end
               end
               ST_BRK: begin
                  state_d = ST_IDLE;
                  dec_en  = 1'b1;
                  dec_brk = 1'b1;
               end
               default: begin
                  state_d = ST_IDLE;
                  dec_en  = 1'b1;
                  dec_ext = 1'b1;
                  dec_brk = 1'b1;
               end
            endcase
         end
      end
   end

   always_comb begin
      p1_dir = 4'd0;
      p2_dir = 4'd0;
      p1_bub = 1'b0;
      p2_bub = 1'b0;
      if (dec_en && dec_ext) begin
         case (rx_data)
            SC_P2_UP:    p2_dir = dir_onehot(DIR_UP);
            SC_P2_DOWN:  p2_dir = dir_onehot(DIR_DOWN);
            SC_P2_LEFT:  p2_dir = dir_onehot(DIR_LEFT);
            SC_P2_RIGHT: p2_dir = dir_onehot(DIR_RIGHT);
            default:     p2_dir = 4'd0;
         endcase
      end else if (dec_en) begin
         case (rx_data)
            SC_P1_UP:    p1_dir = dir_onehot(DIR_UP);
            SC_P1_DOWN:  p1_dir = dir_onehot(DIR_DOWN);
            SC_P1_LEFT:  p1_dir = dir_onehot(DIR_LEFT);
            SC_P1_RIGHT: p1_dir = dir_onehot(DIR_RIGHT);
            SC_P1_BUB:   p1_bub = 1'b1;
            SC_P2_BUB:   p2_bub = 1'b1;
            default:     p1_dir = 4'd0;
         endcase
      end
   end

   assign p1_evt   = '{dir_make: dec_brk ? 4'd0 : p1_dir, dir_brk: dec_brk ? p1_dir : 4'd0,
                       bub_make: p1_bub & ~dec_brk,      bub_brk: p1_bub & dec_brk};
   assign p2_evt   = '{dir_make: dec_brk ? 4'd0 : p2_dir, dir_brk: dec_brk ? p2_dir : 4'd0,
                       bub_make: p2_bub & ~dec_brk,      bub_brk: p2_bub & dec_brk};
   assign held_clr = clear | (rx_err & CLEAR_ON_ERR);

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   bnb_player_keys #(.BUBBLE_PULSE(BUBBLE_PULSE)) u_p1 (
      .clk      (clk),
      .rst      (rst),
      .clear_i  (held_clr),
      .evt_i    (p1_evt),
      .moveen_o (player1_moveen),
      .move_o   (player1_move),
      .bubble_o (player1_bubble)
   );

   bnb_player_keys #(.BUBBLE_PULSE(BUBBLE_PULSE)) u_p2 (
      .clk      (clk),
      .rst      (rst),
      .clear_i  (held_clr),
      .evt_i    (p2_evt),
      .moveen_o (player2_moveen),
      .move_o   (player2_move),
      .bubble_o (player2_bubble)
   );

endmodule

// File: tb/tb_bnb_key_decoder.sv
// Randomized bench for bnb_key_decoder against a prefix/held-key reference model.
module tb_bnb_key_decoder;

   localparam int BP  = 3;
   localparam bit COE = 1'b1;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_err;
   logic       clear;
   logic       player1_moveen, player1_bubble, player2_moveen, player2_bubble;
   logic [1:0] player1_move, player2_move;

   int n_total = 0;
   int n_pass  = 0;
   int bub_hi  = 0;
   int bub_rise = 0;
   logic bub_prev = 1'b0;

   bnb_key_decoder #(.BUBBLE_PULSE(BP), .CLEAR_ON_ERR(COE)) dut (
      .clk            (clk),
      .rst            (rst),
      .rx_data        (rx_data),
      .rx_valid       (rx_valid),
      .rx_err         (rx_err),
      .clear          (clear),
      .player1_moveen (player1_moveen),
      .player1_move   (player1_move),
      .player1_bubble (player1_bubble),
      .player2_moveen (player2_moveen),
      .player2_move   (player2_move),
      .player2_bubble (player2_bubble)
   );

   always #5 clk = ~clk;

   // Reference model: pending prefix flags plus per-player held keys.
   bit m_ext, m_brk;
   bit m_held [2][4];
   int m_last [2];
   bit m_flag [2];
   int m_cnt  [2];
   int ev;
   bit mk, wipe;

   // Returns player*8 + key (key 0..3 = direction, 4 = bubble), or -1.
   function automatic int lookup(input bit ext, input logic [7:0] b);
      if (ext) begin
         case (b)
            8'h75: return 8 + 0;
            8'h72: return 8 + 1;
            8'h6B: return 8 + 2;
            8'h74: return 8 + 3;
            default: return -1;
         endcase
      end
      case (b)
         8'h1D: return 0;
         8'h1B: return 1;
         8'h1C: return 2;
         8'h23: return 3;
         8'h29: return 4;
         8'h5A: return 8 + 4;
         default: return -1;
      endcase
   endfunction

   function automatic bit any_held(input int p);
      return m_held[p][0] | m_held[p][1] | m_held[p][2] | m_held[p][3];
   endfunction

   always @(posedge clk) begin
      ev = -1;
      mk = 1'b0;
      wipe = 1'b0;
      if (rst) begin
         m_ext = 0; m_brk = 0;
         for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < 4; k++) m_held[p][k] = 0;
            m_last[p] = 0; m_flag[p] = 0; m_cnt[p] = 0;
         end
      end else begin
         wipe = clear || (rx_err && COE);
         if (rx_err) begin
            m_ext = 0; m_brk = 0;
         end else if (rx_valid) begin
            if (rx_data == 8'hE1) begin
               m_ext = 0; m_brk = 0;
            end else if (!m_brk && !m_ext && rx_data == 8'hE0) begin
               m_ext = 1;
            end else if (!m_brk && rx_data == 8'hF0) begin
               m_brk = 1;
            end else begin
               ev = lookup(m_ext, rx_data);
               mk = !m_brk;
               m_ext = 0; m_brk = 0;
            end
         end
         for (int p = 0; p < 2; p++) begin
            if (m_cnt[p] > 0) m_cnt[p]--;
            if (wipe) begin
               for (int k = 0; k < 4; k++) m_held[p][k] = 0;
               m_last[p] = 0; m_flag[p] = 0; m_cnt[p] = 0;
            end else if (ev >= 0 && ev / 8 == p) begin
               if (ev % 8 == 4) begin
                  if (mk && !m_flag[p]) begin
                     m_flag[p] = 1; m_cnt[p] = BP;
                  end else if (!mk) begin
                     m_flag[p] = 0;
                  end
               end else if (mk) begin
                  m_held[p][ev % 8] = 1;
                  m_last[p] = ev % 8;
               end else begin
                  m_held[p][ev % 8] = 0;
                  if (m_last[p] == ev % 8 && any_held(p)) begin
                     for (int k = 3; k >= 0; k--) if (m_held[p][k]) m_last[p] = k;
                  end
               end
            end
         end
      end
   end

   task automatic check(input string tag, input int obs, input int exp);
      n_total++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
   endtask

   task automatic check_all();
      check("p1_moveen", int'(player1_moveen), int'(any_held(0)));
      check("p1_move",   int'(player1_move),   m_last[0]);
      check("p1_bubble", int'(player1_bubble), int'(m_cnt[0] != 0));
      check("p2_moveen", int'(player2_moveen), int'(any_held(1)));
      check("p2_move",   int'(player2_move),   m_last[1]);
      check("p2_bubble", int'(player2_bubble), int'(m_cnt[1] != 0));
   endtask

   // Drive one cycle of inputs, then compare on the following falling edge.
   task automatic cyc(input bit v, input logic [7:0] d, input bit e, input bit c, input bit r);
      rx_valid = v; rx_data = d; rx_err = e; clear = c; rst = r;
      @(negedge clk);
      check_all();
      if (player1_bubble) bub_hi++;
      if (player1_bubble && !bub_prev) bub_rise++;
      bub_prev = player1_bubble;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 8'h00, 0, 0, 0);
   endtask

   task automatic send(input logic [7:0] b);
      cyc(1, b, 0, 0, 0);
   endtask

   logic [7:0] pool [14];

   initial begin
      pool = '{8'hE0, 8'hF0, 8'hE1, 8'h1D, 8'h1B, 8'h1C, 8'h23,
               8'h29, 8'h5A, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h00};
      rst = 1; rx_valid = 0; rx_data = 0; rx_err = 0; clear = 0;
      @(negedge clk);
      cyc(0, 8'h00, 0, 0, 1);
      check("rst_p1_moveen", int'(player1_moveen), 0);
      check("rst_p2_move",   int'(player2_move),   0);
      idle(1);

      send(8'h1C); idle(1);
      check("left_p1_move", int'(player1_move), 2);
      send(8'h1D); idle(1);
      check("up_p1_move", int'(player1_move), 0);
      send(8'hF0); send(8'h1D); idle(1);
      check("fallback_p1_move", int'(player1_move), 2);
      send(8'hF0); send(8'h1C); idle(1);
      check("empty_p1_moveen", int'(player1_moveen), 0);
      check("hold_p1_move", int'(player1_move), 2);

      send(8'hE0); send(8'h74); idle(1);
      check("p2_right", int'(player2_move), 3);
      send(8'hE0); send(8'hF0); send(8'h74); idle(1);
      check("p2_release", int'(player2_moveen), 0);
      send(8'h74); idle(2);

      bub_hi = 0; bub_rise = 0;
      send(8'h29); idle(4); send(8'h29); idle(4); send(8'h29); idle(4);
      send(8'hF0); send(8'h29); idle(4); send(8'h29); idle(5);
      check("bubble_hi_cycles", bub_hi, 2 * BP);
      check("bubble_pulses", bub_rise, 2);
      send(8'hF0); send(8'h29); idle(1);

      send(8'h1C); idle(1);
      send(8'hE0); cyc(0, 8'h00, 1, 0, 0); send(8'h75); idle(1);
      check("err_p2_moveen", int'(player2_moveen), 0);
      check("err_p1_moveen", int'(player1_moveen), 0);

      send(8'h1C); send(8'hE0); send(8'h75); cyc(1, 8'h29, 0, 1, 0);
      check("clr_p1_bubble", int'(player1_bubble), 0);
      check("clr_p2_moveen", int'(player2_moveen), 0);
      send(8'hE0); cyc(0, 8'h00, 0, 0, 1); send(8'h75); idle(1);
      check("rst_mid_p2", int'(player2_moveen), 0);

      for (int i = 0; i < 3000; i++) begin
         int r;
         logic [7:0] b;
         r = int'($urandom_range(0, 99));
         b = pool[$urandom_range(0, 13)];
         if (b == 8'h00) b = 8'($urandom);
         if (r < 1)       cyc(0, 8'h00, 0, 0, 1);
         else if (r < 4)  cyc(1'($urandom), b, 1, 0, 0);
         else if (r < 7)  cyc(1'($urandom), b, 0, 1, 0);
         else if (r < 60) cyc(1, b, 0, 0, 0);
         else             cyc(0, 8'h00, 0, 0, 0);
      end
      idle(BP + 2);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
